// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Used by serial_sub and its half_sub cells.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SERIAL_SUB_W = 8;

endpackage

// File: rtl/serial_sub_half_sub.sv
// Gate-level half subtractor: d = x - y, bo = borrow out.
// Two of these plus a borrow flop form the serial full subtractor.
module half_sub (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor (diff = a - b), LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to register the signed-overflow flag on ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = SERIAL_SUB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         ovf
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [CW-1:0] cnt;
    logic          brw;
    logic          d1;
    logic          b1;
    logic          d;
    logic          b2;
    logic          brw_nxt;

    half_sub u_hs0 (
        .d  (d1),
        .bo (b1),
        .x  (a_sr[0]),
        .y  (b_sr[0])
    );

    half_sub u_hs1 (
        .d  (d),
        .bo (b2),
        .x  (d1),
        .y  (brw)
    );

    assign brw_nxt = b1 | b2;

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

`ifdef SERIAL_SUB_OVF_EN
    logic sa;
    logic sb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa         <= 1'b0;
            sb         <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        sa    <= a[W-1];
                        sb    <= b[W-1];
`endif
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[W-1:1]};
                    brw    <= brw_nxt;
                    // hold cnt on the last bit so it never wraps
                    if (cnt == LAST) begin
                        diff       <= {d, res_sr[W-1:1]};
                        borrow_out <= brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (sa != sb) && (d != sa);
`endif
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: randomized and directed operations
// checked against an arithmetic reference model.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   dones = 0;
    bit   after_done = 0;

    serial_sub #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
        exp_t e;
        int   ua;
        int   ub;
        int   sd;
        ua   = int'(av);
        ub   = int'(bv);
        e.d  = W'((ua - ub + 256) % 256);
        e.bo = (ua < ub);
        sd   = int'($signed(av)) - int'($signed(bv));
`ifdef SERIAL_SUB_OVF_EN
        e.ov = (sd > 127) || (sd < -128);
`else
        e.ov = 1'b0;
`endif
        e.cyc = 0;
        return e;
    endfunction

    // Record an expectation whenever the DUT accepts a request.
    always @(posedge clk) begin
        if (!rst && ready && start) begin
            exp_t e;
            e = model(a, b);
            e.cyc = cyc;
            q.push_back(e);
        end
    end

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (after_done) begin
                chk("ready_after_done", 64'(ready), 64'd1);
                chk("done_one_cycle", 64'(done), 64'd0);
                after_done = 0;
            end
            if (done) begin
                dones++;
                after_done = 1;
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("diff", 64'(diff), 64'(e.d));
                    chk("borrow_out", 64'(borrow_out), 64'(e.bo));
                    chk("ovf", 64'(ovf), 64'(e.ov));
                    chk("latency", 64'(cyc), 64'(e.cyc + W + 1));
                    chk("busy_in_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ready && !done) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: got ready=0 expected 1");
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_diff"}, 64'(diff), 64'd0);
        chk({tag, "_borrow"}, 64'(borrow_out), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1;
        start = 0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 0;

        run_op(8'h5A, 8'h23);
        chk("hold_diff_idle", 64'(diff), 64'h37);
        run_op(8'h10, 8'h20);
        run_op(8'h00, 8'h00);
        run_op(8'hFF, 8'h01);

        // starts during SHIFT and DONE must be ignored
        d0 = dones;
        @(negedge clk);
        a = 8'h40;
        b = 8'h01;
        start = 1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = (k == 3) || (k == 9);
            if (start) begin
                a = 8'h00;
                b = 8'hFF;
            end
        end
        start = 0;
        wait_idle();
        repeat (12) @(negedge clk);
        chk("ignored_start_dones", 64'(dones - d0), 64'd1);
        chk("ignored_start_diff", 64'(diff), 64'h3F);

        // reset in the middle of an operation
        d0 = dones;
        @(negedge clk);
        a = 8'h77;
        b = 8'h11;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        chk_reset_vals("abort");
        q.delete();
        @(negedge clk);
        rst = 0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(dones - d0), 64'd0);
        run_op(8'h09, 8'h03);

        run_op(8'h80, 8'h01);
        run_op(8'h05, 8'h03);

        // start held high: back-to-back every W+2 cycles
        d0 = dones;
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        start = 1;
        repeat (40) @(negedge clk);
        start = 0;
        wait_idle();
        chk("b2b_dones", 64'(dones - d0), 64'd4);

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom));
        end

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial W-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Complements the gate-level half-adder blocks in the same arithmetic library.
- Datapath is a full subtractor built from two half-subtractor instances, plus a borrow flip-flop and shift registers.
- Start/done handshake, so it is usable as a low-area, multi-cycle arithmetic unit.

Parameters:
- W, 8, operand and result width in bits. Legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  W  minuend; captured on the accepting edge
- b  input  W  subtrahend; captured on the accepting edge
- ready  output  1  high in IDLE; a new operation can be accepted
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse, high in DONE
- diff  output  W  result; valid from done until the next accepting edge
- borrow_out  output  1  final borrow (1 when a < b unsigned); same validity as diff
- ovf  output  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; ready=1; busy=0; done=0; diff=0; borrow_out=0; ovf=0.
  - Internal operand shift registers, bit counter and borrow register cleared.
- FSM states: IDLE, SHIFT, DONE. Outputs are decoded from registered state only:
  - ready = (state==IDLE)
  - busy = (state==SHIFT)
  - done = (state==DONE)
- IDLE:
  - Edge with start=1: load a and b into shift registers, borrow=0, cnt=0, go to SHIFT.
  - Edge with start=0: stay in IDLE; diff and borrow_out hold their last values.
- SHIFT, one bit per edge:
  - a_bit = a_sr[0], b_bit = b_sr[0].
  - First half subtractor: d1 = a_bit^b_bit, b1 = ~a_bit&b_bit.
  - Second half subtractor: d = d1^borrow, b2 = ~d1&borrow.
  - Update: borrow <= b1|b2. Result shift register shifts right with d entering at the MSB. Operand registers shift right. cnt <= cnt+1.
  - At the edge where cnt==W-1: commit the result register to diff and the new borrow to borrow_out, then go to DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- start handling outside IDLE:
  - start during SHIFT or DONE is ignored, not queued.
  - start held high continuously launches back-to-back operations every W+2 cycles.
- Latency: done is high W cycles after the accepting edge. With W=8, a start accepted at edge 0 gives done high from edge 8 until edge 9.
- Arithmetic: modulo 2^W. borrow_out is the unsigned borrow. diff equals (a-b) mod 2^W for all inputs.
- Counter: cnt is clog2(W) bits wide. cnt never wraps within an operation; it is reset on accept.
- Reset asserted mid-operation aborts the operation. No done is produced, and the outputs take their reset values.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: ovf is registered alongside diff, with ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]) for the captured operands. A sign-bit register captures a[W-1] and b[W-1] on accept.
- Undefined: ovf is tied to 0, and the sign-bit registers are not present.

Decomposition:
- Package serial_sub_pkg:
  - state enum typedef (IDLE, SHIFT, DONE)
  - default width constant SERIAL_SUB_W=8
- Sub-module half_sub:
  - ports d, bo, x, y
  - d = x^y, bo = ~x&y
  - instantiated twice to form the full-subtractor cell
  - purely combinational, no delays

Test Plan:
- W=8, a=0x5A, b=0x23, start pulse -> done exactly 8 cycles after accept, diff=0x37, borrow_out=0, ready returns 1 the cycle after done.
- a=0x10, b=0x20 -> diff=0xF0, borrow_out=1. Then a=0x00, b=0x00 -> diff=0x00, borrow_out=0. Also a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
- Accept a=0x40, b=0x01, then pulse start with a=0x00, b=0xFF on cycles 3 and 8 (SHIFT and DONE) -> both ignored, single done, diff=0x3F.
- Assert rst at cycle 4 of an operation -> all outputs at reset values immediately, no done pulse. A following start with a=0x09, b=0x03 -> diff=0x06.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x05, b=0x03 -> ovf=0. Without the macro, ovf is 0 in both cases.
- start held high for 40 cycles with constant a=0xAA, b=0x55 -> done pulses every 10 cycles, diff=0x55 each time.
